// File: rtl/ani_pkg.sv
// Shared constants and helpers for the FUN display animation sequencer.
package ani_pkg;

    localparam int ANI_W   = 4;
    localparam int FRAME_W = 5;
    localparam int NUM_ANI = 11;

    // Frame limit reported by the limit table for indices with no animation.
    localparam logic [FRAME_W-1:0] DEFAULT_LIMIT = 5'd31;

    typedef enum logic [ANI_W-1:0] {
        ANI_COUNT  = 4'd0,
        ANI_SPIN   = 4'd1,
        ANI_SNAKE  = 4'd2,
        ANI_WAVE   = 4'd3,
        ANI_FILL   = 4'd4,
        ANI_BOUNCE = 4'd5,
        ANI_SCROLL = 4'd6,
        ANI_RAIN   = 4'd7,
        ANI_ZIGZAG = 4'd8,
        ANI_FLASH  = 4'd9,
        ANI_BLINK  = 4'd10
    } ani_e;

    // Index of the last frame: a limit of 0 behaves as a single-frame animation.
    function automatic logic [FRAME_W-1:0] last_frame(input logic [FRAME_W-1:0] lim);
        return (lim == 5'd0) ? 5'd0 : (lim - 5'd1);
    endfunction

    // Next animation index, wrapping after the last valid one.
    function automatic logic [ANI_W-1:0] next_ani(input logic [ANI_W-1:0] cur,
                                                  input logic [ANI_W-1:0] last);
        return (cur == last) ? 4'd0 : (cur + 4'd1);
    endfunction

endpackage

// File: rtl/ani_tick_gen.sv
// Frame-rate prescaler: period max(1, PRESCALE >> speed) cycles, frozen while disabled.
module ani_tick_gen
    import ani_pkg::*;
#(
    parameter int PRESCALE = 2500000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_ena,
    input  logic       i_clr,
    input  logic [1:0] i_speed,
    output logic       o_tick
);

    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    // Terminal count for a given speed shift, clamped so the period is never 0.
    function automatic int term_for(input int sh);
        int p;
        p = PRESCALE >> sh;
        return (p > 1) ? (p - 1) : 0;
    endfunction

    localparam logic [CNT_W-1:0] T0      = CNT_W'(term_for(0));
    localparam logic [CNT_W-1:0] T1      = CNT_W'(term_for(1));
    localparam logic [CNT_W-1:0] T2      = CNT_W'(term_for(2));
    localparam logic [CNT_W-1:0] T3      = CNT_W'(term_for(3));
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_term;

    // Select the terminal count for the requested speed.
    always_comb begin
        w_term = T0;
        case (i_speed)
            2'd0:    w_term = T0;
            2'd1:    w_term = T1;
            2'd2:    w_term = T2;
            2'd3:    w_term = T3;
            default: w_term = T0;
        endcase
    end

    // >= rather than == so a shorter period after a speed change fires at once.
    assign o_tick = i_ena & (r_cnt >= w_term);

    // Count up to the terminal value; a tick or an explicit clear restarts the period.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_ena) begin
            if (i_clr || o_tick) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/ani_sequencer.sv
// Animation/frame sequencer: steps frames at the prescaled rate and advances
// the animation on a button press or after a number of complete loops.
module ani_sequencer
    import ani_pkg::*;
#(
    parameter int PRESCALE      = 2500000,
    parameter int LOOPS_PER_ANI = 3,
    parameter int NUM_ANI       = ani_pkg::NUM_ANI
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               btn_next,
    input  logic               auto_mode,
    input  logic               hold,
    input  logic [1:0]         speed,
    input  logic [FRAME_W-1:0] limit,
    output logic [ANI_W-1:0]   animation,
    output logic [FRAME_W-1:0] frame,
    output logic               frame_stb,
    output logic               loop_done
);

    localparam int                LOOP_W    = (LOOPS_PER_ANI > 1) ? $clog2(LOOPS_PER_ANI) : 1;
    localparam logic [LOOP_W-1:0] LOOP_LAST = LOOP_W'(LOOPS_PER_ANI - 1);
    localparam logic [LOOP_W-1:0] LOOP_ONE  = LOOP_W'(1);
    localparam logic [ANI_W-1:0]  ANI_LAST  = ANI_W'(NUM_ANI - 1);

    logic               r_btn_meta;
    logic               r_btn_sync;
    logic               r_btn_prev;
    logic [ANI_W-1:0]   r_ani;
    logic [FRAME_W-1:0] r_frame;
    logic [LOOP_W-1:0]  r_loop;
    logic               r_stb;
    logic               r_loop_done;

    logic               w_tick;
    logic               w_step;
    logic               w_btn_edge;
    logic               w_wrap;
    logic               w_auto_adv;
    logic               w_adv;

    // Button edges only count while enabled; an edge seen while disabled is lost.
    assign w_btn_edge = ena & r_btn_sync & ~r_btn_prev;

    ani_tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_ena   (ena),
        .i_clr   (w_btn_edge),
        .i_speed (speed),
        .o_tick  (w_tick)
    );

    // A tick is acted on only when the frame counter is not held.
    assign w_step     = w_tick & ~hold;
    // >= also pulls a frame left beyond a newly shortened limit back to 0.
    assign w_wrap     = w_step & (r_frame >= last_frame(limit));
    assign w_auto_adv = w_wrap & auto_mode & (r_loop == LOOP_LAST);
    // Button and auto-advance coinciding still produce a single increment.
    assign w_adv      = w_btn_edge | w_auto_adv;

    // Two-flop synchroniser plus edge-detect history; runs even while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_btn_meta <= 1'b0;
            r_btn_sync <= 1'b0;
            r_btn_prev <= 1'b0;
        end else begin
            r_btn_meta <= btn_next;
            r_btn_sync <= r_btn_meta;
            r_btn_prev <= r_btn_sync;
        end
    end

    // Frame, loop and animation state with registered strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ani       <= ANI_COUNT;
            r_frame     <= '0;
            r_loop      <= '0;
            r_stb       <= 1'b0;
            r_loop_done <= 1'b0;
        end else begin
            r_stb       <= 1'b0;
            r_loop_done <= 1'b0;
            if (ena) begin
                r_stb       <= w_step;
                r_loop_done <= w_wrap;

                // Any animation change restarts at frame 0 so no stale limit is used.
                if (w_adv || w_wrap) begin
                    r_frame <= '0;
                end else if (w_step) begin
                    r_frame <= r_frame + FRAME_W'(1);
                end

                // Loop count clears on advance, otherwise counts wraps and saturates.
                if (w_adv) begin
                    r_loop <= '0;
                end else if (w_wrap && (r_loop < LOOP_LAST)) begin
                    r_loop <= r_loop + LOOP_ONE;
                end

                if (w_adv) begin
                    r_ani <= next_ani(r_ani, ANI_LAST);
                end
            end
        end
    end

    assign animation = r_ani;
    assign frame     = r_frame;
    assign frame_stb = r_stb;
    assign loop_done = r_loop_done;

endmodule

// File: tb/tb_ani_sequencer.sv
// Self-checking bench for ani_sequencer: cycle scoreboard fed by a behavioural
// model, a table of directed phases, and hand-timed multi-cycle sequences.
module tb_ani_sequencer;

    localparam int PRESCALE = 4;
    localparam int LOOPS    = 2;
    localparam int NANI     = 11;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       btn_next = 1'b0;
    logic       auto_mode = 1'b0;
    logic       hold = 1'b0;
    logic [1:0] speed = 2'd0;
    logic [4:0] limit;
    logic [3:0] animation;
    logic [4:0] frame;
    logic       frame_stb;
    logic       loop_done;

    logic [4:0] lim_tab [0:15];
    logic       ovr_en = 1'b0;
    logic [4:0] ovr_val = 5'd0;

    int n_checks = 0;
    int n_fail   = 0;

    assign limit = ovr_en ? ovr_val : lim_tab[animation];

    ani_sequencer #(
        .PRESCALE      (PRESCALE),
        .LOOPS_PER_ANI (LOOPS),
        .NUM_ANI       (NANI)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .btn_next  (btn_next),
        .auto_mode (auto_mode),
        .hold      (hold),
        .speed     (speed),
        .limit     (limit),
        .animation (animation),
        .frame     (frame),
        .frame_stb (frame_stb),
        .loop_done (loop_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    typedef struct {
        int anim;
        int frame;
        int stb;
        int ld;
    } exp_t;

    exp_t sb_q[$];
    exp_t e_chk;

    int m_cnt, m_anim, m_frame, m_loop, m_p, m_lim, m_stb, m_ld;
    int m_meta, m_sync, m_prev, m_edge, m_tick, m_wrap, m_adv;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_cnt = 0; m_anim = 0; m_frame = 0; m_loop = 0;
                m_meta = 0; m_sync = 0; m_prev = 0;
                sb_q.delete();
                sb_q.push_back('{0, 0, 0, 0});
            end else begin
                m_p = PRESCALE >> speed;
                if (m_p < 1) m_p = 1;
                m_lim = ovr_en ? int'(ovr_val) : int'(lim_tab[m_anim]);
                if (m_lim == 0) m_lim = 1;
                m_edge = (m_sync == 1 && m_prev == 0) ? 1 : 0;
                m_prev = m_sync;
                m_sync = m_meta;
                m_meta = int'(btn_next);
                m_stb = 0;
                m_ld  = 0;
                if (ena) begin
                    m_tick = (m_cnt >= m_p - 1) ? 1 : 0;
                    m_wrap = 0;
                    m_adv  = 0;
                    if (m_tick == 1 && !hold) begin
                        m_stb = 1;
                        if (m_frame >= m_lim - 1) begin
                            m_wrap = 1;
                            m_ld = 1;
                            m_frame = 0;
                        end else begin
                            m_frame = m_frame + 1;
                        end
                    end
                    if (m_wrap == 1) begin
                        if (auto_mode && m_loop == LOOPS - 1) begin
                            m_adv = 1;
                            m_loop = 0;
                        end else if (m_loop < LOOPS - 1) begin
                            m_loop = m_loop + 1;
                        end
                    end
                    m_cnt = (m_tick == 1) ? 0 : m_cnt + 1;
                    if (m_edge == 1) begin
                        m_adv = 1; m_loop = 0; m_cnt = 0;
                    end
                    if (m_adv == 1) begin
                        m_anim = (m_anim == NANI - 1) ? 0 : m_anim + 1;
                        m_frame = 0;
                    end
                end
                sb_q.push_back('{m_anim, m_frame, m_stb, m_ld});
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e_chk = sb_q.pop_front();
                chk("sb_anim",  int'(animation), e_chk.anim);
                chk("sb_frame", int'(frame),     e_chk.frame);
                chk("sb_stb",   int'(frame_stb), e_chk.stb);
                chk("sb_ld",    int'(loop_done), e_chk.ld);
            end
        end
    end

    // ---------------- directed phase table ----------------
    typedef struct {
        int speed;
        int hold;
        int ena;
        int ovr;
        int ovr_val;
        int cycles;
        int chk_stb;
        int exp_stb;
        int chk_ld;
        int exp_ld;
        int chk_zero;
        int chk_frozen;
    } vec_t;

    vec_t vt [0:5];
    int   snap;
    int   stb_cnt;

    task automatic press();
        btn_next = 1'b1;
        repeat (4) @(negedge clk);
        btn_next = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        lim_tab[0] = 5'd10; lim_tab[1] = 5'd12; lim_tab[2]  = 5'd8;  lim_tab[3]  = 5'd6;
        lim_tab[4] = 5'd4;  lim_tab[5] = 5'd16; lim_tab[6]  = 5'd3;  lim_tab[7]  = 5'd5;
        lim_tab[8] = 5'd7;  lim_tab[9] = 5'd9;  lim_tab[10] = 5'd31;
        for (int i = 11; i < 16; i++) lim_tab[i] = 5'd31;

        //           spd hld ena ovr val cyc cs es cl el zero frozen
        vt[0] = '{2, 0, 1, 0, 0, 6,  1, 1, 0, 0, 0, 0};
        vt[1] = '{3, 0, 1, 0, 0, 6,  1, 1, 0, 0, 0, 0};
        vt[2] = '{2, 0, 1, 1, 0, 6,  1, 1, 1, 1, 1, 0};
        vt[3] = '{1, 0, 1, 0, 0, 7,  0, 0, 0, 0, 0, 0};
        vt[4] = '{0, 1, 1, 0, 0, 20, 1, 0, 1, 0, 0, 1};
        vt[5] = '{0, 0, 0, 0, 0, 20, 1, 0, 1, 0, 0, 1};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_anim",  int'(animation), 0);
        chk("rst_frame", int'(frame), 0);
        chk("rst_stb",   int'(frame_stb), 0);
        chk("rst_ld",    int'(loop_done), 0);
        rst_n = 1'b1;

        // Frames 0..9 every 4 cycles, first wrap at edge 40
        stb_cnt = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (frame_stb) stb_cnt++;
            if (k == 39) chk("t1_frame39", int'(frame), 9);
        end
        chk("t1_wrap_frame", int'(frame), 0);
        chk("t1_wrap_ld",    int'(loop_done), 1);
        chk("t1_anim",       int'(animation), 0);
        chk("t1_stb_count",  stb_cnt, 10);

        // Auto-advance on the second wrap at edge 80, then limit 12
        auto_mode = 1'b1;
        for (int k = 41; k <= 128; k++) begin
            @(negedge clk);
            if (k == 79) begin
                chk("t2_anim79",  int'(animation), 0);
                chk("t2_frame79", int'(frame), 9);
            end
            if (k == 80) begin
                chk("t2_anim80",  int'(animation), 1);
                chk("t2_frame80", int'(frame), 0);
                chk("t2_ld80",    int'(loop_done), 1);
            end
            if (k == 124) chk("t2_frame124", int'(frame), 11);
            if (k == 128) begin
                chk("t2_frame128", int'(frame), 0);
                chk("t2_anim128",  int'(animation), 1);
            end
        end
        auto_mode = 1'b0;

        // Step the animation to 10 with button presses
        for (int i = 0; i < 9; i++) press();
        chk("t3_anim10", int'(animation), 10);

        // Button latency, wrap 10 -> 0, held level advances once
        btn_next = 1'b1;
        @(negedge clk); chk("t3_lat1", int'(animation), 10);
        @(negedge clk); chk("t3_lat2", int'(animation), 10);
        @(negedge clk);
        chk("t3_lat3_anim",  int'(animation), 0);
        chk("t3_lat3_frame", int'(frame), 0);
        auto_mode = 1'b1;
        for (int k = 1; k <= 85; k++) begin
            @(negedge clk);
            if (k == 3) chk("t3_presc_frame", int'(frame), 0);
            if (k == 4) begin
                chk("t3_first_tick", int'(frame), 1);
                chk("t3_first_stb",  int'(frame_stb), 1);
            end
            if (k == 7) begin
                chk("t3_held_once", int'(animation), 0);
                btn_next = 1'b0;
            end
            if (k == 77) btn_next = 1'b1;
            if (k == 79) begin
                chk("t4_anim_pre",  int'(animation), 0);
                chk("t4_frame_pre", int'(frame), 9);
            end
            if (k == 80) begin
                chk("t4_anim_once", int'(animation), 1);
                chk("t4_frame",     int'(frame), 0);
                chk("t4_ld",        int'(loop_done), 1);
            end
        end
        chk("t4_anim_after", int'(animation), 1);
        btn_next  = 1'b0;
        auto_mode = 1'b0;
        repeat (4) @(negedge clk);

        // Table-driven phases: speed clamp, limit 0, hold, ena low
        for (int v = 0; v < 6; v++) begin
            speed   = 2'(vt[v].speed);
            hold    = (vt[v].hold != 0);
            ena     = (vt[v].ena != 0);
            ovr_en  = (vt[v].ovr != 0);
            ovr_val = 5'(vt[v].ovr_val);
            snap    = m_frame;
            for (int c = 0; c < vt[v].cycles; c++) begin
                @(negedge clk);
                if (vt[v].chk_stb != 0)    chk($sformatf("v%0d_stb", v), int'(frame_stb), vt[v].exp_stb);
                if (vt[v].chk_ld != 0)     chk($sformatf("v%0d_ld", v), int'(loop_done), vt[v].exp_ld);
                if (vt[v].chk_zero != 0)   chk($sformatf("v%0d_zero", v), int'(frame), 0);
                if (vt[v].chk_frozen != 0) chk($sformatf("v%0d_frozen", v), int'(frame), snap);
            end
        end
        chk("tbl_anim", int'(animation), 1);

        // Button edge while disabled is dropped
        ena = 1'b0;
        btn_next = 1'b1;
        repeat (5) @(negedge clk);
        ena = 1'b1;
        repeat (5) @(negedge clk);
        chk("ena_btn_dropped", int'(animation), 1);
        btn_next = 1'b0;
        repeat (3) @(negedge clk);

        // Asynchronous reset mid-count
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_anim",  int'(animation), 0);
        chk("arst_frame", int'(frame), 0);
        chk("arst_stb",   int'(frame_stb), 0);
        chk("arst_ld",    int'(loop_done), 0);
        repeat (3) @(negedge clk);
        speed = 2'd0; hold = 1'b0; ena = 1'b1; ovr_en = 1'b0;
        rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k < 4) begin
                chk($sformatf("rel_stb%0d", k), int'(frame_stb), 0);
                chk($sformatf("rel_frame%0d", k), int'(frame), 0);
            end else begin
                chk("rel_first_stb",   int'(frame_stb), 1);
                chk("rel_first_frame", int'(frame), 1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
